// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run-control harness: FSM states,
// default halt word and stop-reason codes.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4,
    ST_TMO  = 3'd5
  } run_state_e;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    STOP_NONE = 2'd0,
    STOP_HALT = 2'd1,
    STOP_TMO  = 2'd2,
    STOP_RST  = 2'd3
  } stop_reason_e;

endpackage

// File: rtl/cpu_run_stall_det.sv
// Self-loop detector: flags the enabled cycle in which the PC has
// repeated the previous enabled PC STALL_LIMIT times in a row.
module cpu_run_stall_det #(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            stall
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [PC_W-1:0] prev_q, prev_d;
  logic            vld_q, vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            match;

  always_comb begin
    prev_d = prev_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    stall  = 1'b0;
    match  = vld_q && (pc == prev_q);
    // Streak only moves on enabled cycles, so pausing keeps it.
    if (en) begin
      prev_d = pc;
      vld_d  = 1'b1;
      if (match) begin
        stall = (cnt_q == CW'(STALL_LIMIT - 1));
        if (!stall) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control harness: CPU reset sequencing, run/step clock-enable,
// cycle counting, halt/self-loop detection and timeout.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 32,
  parameter int          RST_HOLD    = 4,
  parameter int          MAX_CYCLES  = 1000,
  parameter int          STALL_LIMIT = 3,
  parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HW = $clog2(RST_HOLD + 1);

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_en_q, cpu_en_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [PC_W-1:0]  hpc_q, hpc_d;
  logic             stall;
  logic             halt;

  cpu_run_stall_det #(
    .PC_W       (PC_W),
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk  (clk),
    .rst  (rst),
    .en   (cpu_en_q),
    .pc   (pc),
    .stall(stall)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    cpu_rst_d = cpu_rst_q;
    cpu_en_d  = 1'b0;
    done_d    = done_q;
    tmo_d     = tmo_q;
    hpc_d     = hpc_q;
    halt      = cpu_en_q && ((instr == HALT_INSTR) || stall);
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HW'(RST_HOLD - 1)) begin
          state_d   = ST_IDLE;
          cpu_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cpu_en_d = 1'b1;
        end else if (step) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        cnt_d = cnt_inc;
        // Priority: halt, then timeout, then stop / end of step.
        if (halt) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hpc_d   = pc;
        end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
          state_d = ST_TMO;
          tmo_d   = 1'b1;
        end else if (state_q == ST_RUN && !stop) begin
          cpu_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      cnt_q     <= '0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      hpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      cpu_rst_q <= cpu_rst_d;
      cpu_en_q  <= cpu_en_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      hpc_q     <= hpc_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_en      = cpu_en_q;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign halt_pc     = hpc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int RST_HOLD    = 4;
  localparam int MAX_CYCLES  = 1000;
  localparam int STALL_LIMIT = 3;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, step = 1'b0, stop = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic        cpu_rst, cpu_en, done, timeout;
  logic [31:0] cycle_count, halt_pc;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_HOLD(RST_HOLD),
    .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT),
    .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop),
    .pc(pc), .instr(instr), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .cycle_count(cycle_count), .done(done), .timeout(timeout),
    .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase of the run plus history of enabled PCs.
  localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3;
  localparam int M_DONE = 4, M_TMO = 5;

  int          m_mode = M_HOLD;
  int          m_hold = 0;
  bit          m_rst = 1'b1, m_en = 1'b0, m_done = 1'b0, m_tmo = 1'b0;
  longint      m_cnt = 0;
  logic [31:0] m_hpc = '0;
  logic [31:0] hist[$];
  bit          stalled;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_HOLD; m_hold = 0; m_rst = 1'b1; m_en = 1'b0;
      m_cnt = 0; m_done = 1'b0; m_tmo = 1'b0; m_hpc = '0;
      hist.delete();
    end else begin
      case (m_mode)
        M_HOLD: begin
          m_hold++;
          if (m_hold == RST_HOLD) begin m_mode = M_IDLE; m_rst = 1'b0; end
        end
        M_IDLE: begin
          if (start) begin m_mode = M_RUN; m_en = 1'b1; end
          else if (step) begin m_mode = M_STEP; m_en = 1'b1; end
        end
        M_RUN, M_STEP: begin
          hist.push_back(pc);
          if (hist.size() > STALL_LIMIT + 1) void'(hist.pop_front());
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          stalled = (hist.size() == STALL_LIMIT + 1);
          foreach (hist[i]) if (hist[i] != pc) stalled = 1'b0;
          if (instr == HALT || stalled) begin
            m_mode = M_DONE; m_done = 1'b1; m_hpc = pc; m_en = 1'b0;
          end else if (m_cnt == MAX_CYCLES) begin
            m_mode = M_TMO; m_tmo = 1'b1; m_en = 1'b0;
          end else if (m_mode == M_RUN && !stop) begin
            m_en = 1'b1;
          end else begin
            m_mode = M_IDLE; m_en = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("cpu_rst", cpu_rst, m_rst);
      cmp("cpu_en", cpu_en, m_en);
      cmp("cycle_count", cycle_count, m_cnt);
      cmp("done", done, m_done);
      cmp("timeout", timeout, m_tmo);
      cmp("halt_pc", halt_pc, m_hpc);
    end
  end

  task automatic drive(input bit r, input bit s, input bit st, input bit sp,
                       input logic [31:0] p, input logic [31:0] i);
    rst = r; start = s; step = st; stop = sp; pc = p; instr = i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, NOP);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 32'h0, NOP);
    repeat (RST_HOLD) idle();
    cmp("lit_idle_after_reset", cpu_rst, 0);
  endtask

  function automatic stop_reason_e reason();
    if (done) return STOP_HALT;
    if (timeout) return STOP_TMO;
    if (cpu_rst) return STOP_RST;
    return STOP_NONE;
  endfunction

  task automatic report(input string name);
    stop_reason_e r;
    r = reason();
    $display("scenario %s ended: %s", name, r.name());
  endtask

  logic [31:0] loop_pcs[6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
  logic [31:0] run_pcs[5] = '{32'h10c, 32'h110, 32'h114, 32'h118, 32'h118};

  initial begin
    logic [31:0] rpc;
    // Reset sequencing
    drive(1, 0, 0, 0, 32'h0, NOP);
    chk_on = 1'b1;
    drive(1, 1, 1, 0, 32'h0, NOP);
    cmp("lit_rst_cpu_rst", cpu_rst, 1);
    for (int k = 1; k <= RST_HOLD; k++) begin
      drive(0, 1, 1, 1, 32'h0, NOP);
      cmp("lit_hold_cpu_rst", cpu_rst, (k < RST_HOLD) ? 1 : 0);
      cmp("lit_hold_cpu_en", cpu_en, 0);
    end
    report("reset");

    // Halt instruction on 7th enabled cycle
    drive(0, 1, 0, 0, 32'h0, NOP);
    cmp("lit_run_en", cpu_en, 1);
    for (int k = 1; k <= 7; k++)
      drive(0, 0, 0, 0, 32'(4 * (k - 1)), (k == 7) ? HALT : NOP);
    cmp("lit_halt_done", done, 1);
    cmp("lit_halt_count", cycle_count, 7);
    cmp("lit_halt_pc", halt_pc, 24);
    cmp("lit_halt_en", cpu_en, 0);
    report("halt_instr");

    // Self-loop 0,4,8,8,8,8
    do_reset();
    drive(0, 1, 0, 0, 32'h0, NOP);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, loop_pcs[k], NOP);
      if (k == 4) cmp("lit_loop_not_yet", done, 0);
    end
    cmp("lit_loop_done", done, 1);
    cmp("lit_loop_pc", halt_pc, 8);
    cmp("lit_loop_count", cycle_count, 6);
    report("self_loop");

    // Step three times, then run/stop, then resume the streak
    do_reset();
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 1, 0, 32'h0, NOP);
      cmp("lit_step_en", cpu_en, 1);
      drive(0, 0, 0, 0, 32'(32'h100 + 4 * j), NOP);
      cmp("lit_step_en_off", cpu_en, 0);
      idle();
    end
    cmp("lit_step_count", cycle_count, 3);
    drive(0, 1, 0, 0, 32'h0, NOP);
    for (int k = 0; k < 5; k++)
      drive(0, 0, 0, (k == 4), run_pcs[k], NOP);
    cmp("lit_stop_en", cpu_en, 0);
    cmp("lit_stop_count", cycle_count, 8);
    idle();
    drive(0, 1, 0, 0, 32'h0, NOP);
    drive(0, 0, 0, 0, 32'h118, NOP);
    cmp("lit_streak_mid", done, 0);
    drive(0, 0, 0, 0, 32'h118, NOP);
    cmp("lit_streak_done", done, 1);
    cmp("lit_streak_count", cycle_count, 10);
    report("step_pause");

    // Timeout
    do_reset();
    drive(0, 1, 0, 0, 32'h0, NOP);
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      drive(0, 0, 0, 0, 32'(4 * k), NOP);
      if (k == MAX_CYCLES - 1) cmp("lit_tmo_early", timeout, 0);
    end
    cmp("lit_tmo", timeout, 1);
    cmp("lit_tmo_done", done, 0);
    cmp("lit_tmo_count", cycle_count, MAX_CYCLES);
    repeat (3) drive(0, 1, 0, 0, 32'h0, NOP);
    cmp("lit_tmo_start_ign", cpu_en, 0);
    cmp("lit_tmo_frozen", cycle_count, MAX_CYCLES);
    report("timeout");

    // Halt on cycle MAX_CYCLES
    do_reset();
    drive(0, 1, 0, 0, 32'h0, NOP);
    for (int k = 1; k <= MAX_CYCLES; k++)
      drive(0, 0, 0, 0, 32'(4 * k), (k == MAX_CYCLES) ? HALT : NOP);
    cmp("lit_both_done", done, 1);
    cmp("lit_both_tmo", timeout, 0);
    report("halt_at_limit");

    // rst mid-RUN
    do_reset();
    drive(0, 1, 0, 0, 32'h0, NOP);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 32'(4 * k), NOP);
    drive(1, 0, 0, 0, 32'h0, NOP);
    cmp("lit_mid_rst", cpu_rst, 1);
    cmp("lit_mid_en", cpu_en, 0);
    cmp("lit_mid_count", cycle_count, 0);
    report("mid_run_reset");

    // Random traffic
    rpc = '0;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        case ($urandom % 4)
          0, 1: rpc = rpc;
          2: rpc = rpc + 32'h4;
          default: rpc = 32'($urandom % 8) << 2;
        endcase
        drive(($urandom % 300) == 0, ($urandom % 6) == 0,
              ($urandom % 6) == 0, ($urandom % 12) == 0, rpc,
              (($urandom % 60) == 0) ? HALT : NOP);
      end
      report("random");
    end

    idle();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
